// File: rtl/packet_gate_mp_if.sv
// Bundle of the decision, ingress, egress and statistics signals for all
// lanes of packet_gate_mp. The gate itself connects through the slave
// modport; whatever drives and observes the gate connects through master.
interface packet_gate_mp_if #(
    parameter int NUM_PORT   = 2,
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
);
    // Per-lane control
    logic [NUM_PORT-1:0]            cfg_bypass;
    logic [NUM_PORT-1:0]            cnt_clear;

    // Decision push interface from the rule engine
    logic [NUM_PORT-1:0]            s_dec_valid;
    logic [NUM_PORT-1:0]            s_dec_allow;
    logic [NUM_PORT-1:0]            s_dec_ready;

    // Ingress AXIS (from adapter RX)
    logic [NUM_PORT-1:0]            s_axis_tvalid;
    logic [NUM_PORT-1:0]            s_axis_tlast;
    logic [DATA_WIDTH*NUM_PORT-1:0] s_axis_tdata;
    logic [KEEP_WIDTH*NUM_PORT-1:0] s_axis_tkeep;
    logic [16*NUM_PORT-1:0]         s_axis_tuser_size;
    logic [16*NUM_PORT-1:0]         s_axis_tuser_src;
    logic [16*NUM_PORT-1:0]         s_axis_tuser_dst;
    logic [NUM_PORT-1:0]            s_axis_tready;

    // Egress AXIS (towards QDMA TX)
    logic [NUM_PORT-1:0]            m_axis_tvalid;
    logic [NUM_PORT-1:0]            m_axis_tlast;
    logic [DATA_WIDTH*NUM_PORT-1:0] m_axis_tdata;
    logic [KEEP_WIDTH*NUM_PORT-1:0] m_axis_tkeep;
    logic [16*NUM_PORT-1:0]         m_axis_tuser_size;
    logic [16*NUM_PORT-1:0]         m_axis_tuser_src;
    logic [16*NUM_PORT-1:0]         m_axis_tuser_dst;
    logic [NUM_PORT-1:0]            m_axis_tready;

    // Statistics
    logic [CNT_WIDTH*NUM_PORT-1:0]  cnt_in;
    logic [CNT_WIDTH*NUM_PORT-1:0]  cnt_pass;
    logic [CNT_WIDTH*NUM_PORT-1:0]  cnt_drop;

    // View seen by the gate
    modport slave (
        input  cfg_bypass, cnt_clear,
        input  s_dec_valid, s_dec_allow,
        output s_dec_ready,
        input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep,
        input  s_axis_tuser_size, s_axis_tuser_src, s_axis_tuser_dst,
        output s_axis_tready,
        output m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep,
        output m_axis_tuser_size, m_axis_tuser_src, m_axis_tuser_dst,
        input  m_axis_tready,
        output cnt_in, cnt_pass, cnt_drop
    );

    // View seen by the surrounding logic that feeds and drains the gate
    modport master (
        output cfg_bypass, cnt_clear,
        output s_dec_valid, s_dec_allow,
        input  s_dec_ready,
        output s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep,
        output s_axis_tuser_size, s_axis_tuser_src, s_axis_tuser_dst,
        input  s_axis_tready,
        input  m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep,
        input  m_axis_tuser_size, m_axis_tuser_src, m_axis_tuser_dst,
        output m_axis_tready,
        input  cnt_in, cnt_pass, cnt_drop
    );
endinterface

// File: rtl/packet_gate_mp.sv
// Multi-port packet gate. Each lane forwards or drops whole AXIS packets
// according to the decision at the head of its own decision FIFO (or
// forwards everything while bypassed), and counts in/pass/drop packets.
// Lanes are fully independent; payload is wired straight through and only
// the valid/ready handshake is gated, so no latency is added.
module packet_gate_mp #(
    parameter int NUM_PORT   = 2,
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64,
    parameter int DEC_DEPTH  = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic               axis_aclk,
    input  logic               box_rst,
    packet_gate_mp_if.slave    bus
);

    localparam int AW = (DEC_DEPTH > 1) ? $clog2(DEC_DEPTH) : 1;
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] FULL_LEVEL = OW'(DEC_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } lane_state_t;

    // Payload and sideband never change, only the handshake is gated
    assign bus.m_axis_tdata      = bus.s_axis_tdata;
    assign bus.m_axis_tkeep      = bus.s_axis_tkeep;
    assign bus.m_axis_tlast      = bus.s_axis_tlast;
    assign bus.m_axis_tuser_size = bus.s_axis_tuser_size;
    assign bus.m_axis_tuser_src  = bus.s_axis_tuser_src;
    assign bus.m_axis_tuser_dst  = bus.s_axis_tuser_dst;

    for (genvar p = 0; p < NUM_PORT; p++) begin : g_lane

        lane_state_t          state_q;
        lane_state_t          state_d;
        logic [DEC_DEPTH-1:0] dec_mem_q;
        logic [AW-1:0]        wr_ptr_q;
        logic [AW-1:0]        rd_ptr_q;
        logic [OW-1:0]        level_q;
        logic [CNT_WIDTH-1:0] cnt_in_q;
        logic [CNT_WIDTH-1:0] cnt_pass_q;
        logic [CNT_WIDTH-1:0] cnt_drop_q;

        logic fifo_full;
        logic fifo_empty;
        logic head_allow;
        logic push;
        logic pop;
        logic pkt_pass;
        logic s_ready;
        logic m_valid;
        logic beat_hs;
        logic last_hs;

        assign fifo_full  = (level_q == FULL_LEVEL);
        assign fifo_empty = (level_q == '0);
        assign head_allow = dec_mem_q[rd_ptr_q];
        assign push       = bus.s_dec_valid[p] & ~fifo_full;

        // Handshake gating and next state; in IDLE the packet mode comes
        // straight from bypass/FIFO head so the first beat sees no delay,
        // afterwards it is held by the PASS/DROP state until tlast.
        always_comb begin
            state_d  = state_q;
            pkt_pass = 1'b0;
            s_ready  = 1'b0;
            m_valid  = 1'b0;
            pop      = 1'b0;
            beat_hs  = 1'b0;
            last_hs  = 1'b0;
            case (state_q)
                IDLE: begin
                    pkt_pass = bus.cfg_bypass[p] | head_allow;
                    if (bus.cfg_bypass[p] || !fifo_empty) begin
                        s_ready = pkt_pass ? bus.m_axis_tready[p] : 1'b1;
                        m_valid = pkt_pass & bus.s_axis_tvalid[p];
                    end
                end
                PASS: begin
                    pkt_pass = 1'b1;
                    s_ready  = bus.m_axis_tready[p];
                    m_valid  = bus.s_axis_tvalid[p];
                end
                DROP: begin
                    s_ready = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            if (box_rst) begin
                s_ready = 1'b0;
                m_valid = 1'b0;
            end
            beat_hs = bus.s_axis_tvalid[p] & s_ready;
            last_hs = beat_hs & bus.s_axis_tlast[p];
            if (beat_hs) begin
                if (state_q == IDLE) begin
                    pop = ~bus.cfg_bypass[p];
                    if (!bus.s_axis_tlast[p]) begin
                        state_d = pkt_pass ? PASS : DROP;
                    end
                end else if (bus.s_axis_tlast[p]) begin
                    state_d = IDLE;
                end
            end
        end

        // Lane state register
        always_ff @(posedge axis_aclk or posedge box_rst) begin
            if (box_rst) begin
                state_q <= IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // Decision FIFO; a pop can only happen when an entry is present
        // because the IDLE gating requires a non-empty FIFO outside bypass
        always_ff @(posedge axis_aclk or posedge box_rst) begin
            if (box_rst) begin
                dec_mem_q <= '0;
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                level_q   <= '0;
            end else begin
                if (push) begin
                    dec_mem_q[wr_ptr_q] <= bus.s_dec_allow[p];
                    wr_ptr_q            <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                case ({push, pop})
                    2'b10:   level_q <= level_q + OW'(1);
                    2'b01:   level_q <= level_q - OW'(1);
                    default: level_q <= level_q;
                endcase
            end
        end

        // Packet counters bump on the tlast handshake and wrap naturally;
        // a clear in the same cycle wins over the increment
        always_ff @(posedge axis_aclk or posedge box_rst) begin
            if (box_rst) begin
                cnt_in_q   <= '0;
                cnt_pass_q <= '0;
                cnt_drop_q <= '0;
            end else if (bus.cnt_clear[p]) begin
                cnt_in_q   <= '0;
                cnt_pass_q <= '0;
                cnt_drop_q <= '0;
            end else if (last_hs) begin
                cnt_in_q <= cnt_in_q + CNT_WIDTH'(1);
                if (pkt_pass) begin
                    cnt_pass_q <= cnt_pass_q + CNT_WIDTH'(1);
                end else begin
                    cnt_drop_q <= cnt_drop_q + CNT_WIDTH'(1);
                end
            end
        end

        assign bus.s_dec_ready[p]                     = ~fifo_full;
        assign bus.s_axis_tready[p]                   = s_ready;
        assign bus.m_axis_tvalid[p]                   = m_valid;
        assign bus.cnt_in[p*CNT_WIDTH +: CNT_WIDTH]   = cnt_in_q;
        assign bus.cnt_pass[p*CNT_WIDTH +: CNT_WIDTH] = cnt_pass_q;
        assign bus.cnt_drop[p*CNT_WIDTH +: CNT_WIDTH] = cnt_drop_q;
    end

endmodule

// File: tb/tb_packet_gate_mp.sv
// Bench for packet_gate_mp: a two-lane full-width instance exercised via a
// per-lane scoreboard and decision model, plus a narrow one-lane instance
// with 3-bit counters for counter wrap.
module tb_packet_gate_mp;
    localparam int NP  = 2;
    localparam int DW  = 512;
    localparam int KW  = 64;
    localparam int CW  = 32;
    localparam int DEP = 8;

    typedef struct packed {
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    beat_t exp_q[NP][$];
    bit    dec_model[NP][$];

    always #5 clk = ~clk;

    // Cycle counter for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    packet_gate_mp_if #(.NUM_PORT(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW)) ifc ();
    packet_gate_mp #(.NUM_PORT(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEC_DEPTH(DEP), .CNT_WIDTH(CW)) dut (
        .axis_aclk (clk),
        .box_rst   (rst),
        .bus       (ifc)
    );

    packet_gate_mp_if #(.NUM_PORT(1), .DATA_WIDTH(8), .KEEP_WIDTH(1), .CNT_WIDTH(3)) ifs ();
    packet_gate_mp #(.NUM_PORT(1), .DATA_WIDTH(8), .KEEP_WIDTH(1), .DEC_DEPTH(2), .CNT_WIDTH(3)) dut_small (
        .axis_aclk (clk),
        .box_rst   (rst),
        .bus       (ifs)
    );

    // Egress monitor: every handshaken beat must match the scoreboard head
    always @(negedge clk) begin
        beat_t got;
        beat_t want;
        if (!rst) begin
            for (int p = 0; p < NP; p++) begin
                if (ifc.m_axis_tvalid[p] && ifc.m_axis_tready[p]) begin
                    got = {ifc.m_axis_tlast[p], ifc.m_axis_tkeep[p*KW +: KW], ifc.m_axis_tdata[p*DW +: DW]};
                    checks++;
                    if (exp_q[p].size() == 0) begin
                        errors++;
                        $display("[TB] FAIL egress_unexpected port%0d: got last=%0b data=%h, required no beat",
                                 p, got.last, got.data[63:0]);
                    end else begin
                        want = exp_q[p].pop_front();
                        if (got !== want) begin
                            errors++;
                            $display("[TB] FAIL egress_beat port%0d: got last=%0b keep=%h data=%h, required last=%0b keep=%h data=%h",
                                     p, got.last, got.keep, got.data[63:0], want.last, want.keep, want.data[63:0]);
                        end
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dec(input int p, input bit allow);
        int n = 0;
        ifc.s_dec_valid[p] = 1'b1;
        ifc.s_dec_allow[p] = allow;
        @(negedge clk);
        while (!ifc.s_dec_ready[p] && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("[TB] FAIL dec_push_timeout port%0d: s_dec_ready=%0b, required 1", p, ifc.s_dec_ready[p]);
        end else begin
            dec_model[p].push_back(allow);
        end
        @(posedge clk);
        #1;
        ifc.s_dec_valid[p] = 1'b0;
    endtask

    task automatic make_beat(input bit last, output beat_t bt);
        for (int w = 0; w < DW/32; w++) bt.data[w*32 +: 32] = $urandom;
        bt.keep = {$urandom, $urandom};
        bt.last = last;
    endtask

    task automatic send_pkt(input int p, input int nbeats);
        bit    pass;
        beat_t bt;
        int    n;
        if (ifc.cfg_bypass[p]) begin
            pass = 1'b1;
        end else if (dec_model[p].size() == 0) begin
            pass = 1'b0;
            errors++;
            $display("[TB] FAIL model_empty port%0d: no decision queued, required one", p);
        end else begin
            pass = dec_model[p].pop_front();
        end
        for (int b = 0; b < nbeats; b++) begin
            make_beat(b == nbeats - 1, bt);
            ifc.s_axis_tdata[p*DW +: DW] = bt.data;
            ifc.s_axis_tkeep[p*KW +: KW] = bt.keep;
            ifc.s_axis_tlast[p]          = bt.last;
            ifc.s_axis_tvalid[p]         = 1'b1;
            if (pass) exp_q[p].push_back(bt);
            n = 0;
            @(negedge clk);
            while (!ifc.s_axis_tready[p] && n < 200) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n >= 200) begin
                errors++;
                $display("[TB] FAIL ingress_timeout port%0d beat%0d: s_axis_tready=0, required 1", p, b);
            end
            @(posedge clk);
            #1;
        end
        ifc.s_axis_tvalid[p] = 1'b0;
        ifc.s_axis_tlast[p]  = 1'b0;
    endtask

    task automatic wait_drain(input int p);
        int n = 0;
        while (exp_q[p].size() != 0 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q[p].size() != 0) begin
            errors++;
            $display("[TB] FAIL drain port%0d: %0d beats outstanding, required 0", p, exp_q[p].size());
        end
    endtask

    task automatic clear_cnt(input logic [NP-1:0] mask);
        ifc.cnt_clear = mask;
        tick();
        ifc.cnt_clear = '0;
    endtask

    task automatic check_cnt(input string name, input int p, input logic [CW-1:0] in_e,
                             input logic [CW-1:0] pass_e, input logic [CW-1:0] drop_e);
        logic [CW-1:0] a_in, a_pass, a_drop;
        a_in   = ifc.cnt_in[p*CW +: CW];
        a_pass = ifc.cnt_pass[p*CW +: CW];
        a_drop = ifc.cnt_drop[p*CW +: CW];
        checks++;
        if ({a_in, a_pass, a_drop} !== {in_e, pass_e, drop_e}) begin
            errors++;
            $display("[TB] FAIL %s port%0d counters: in/pass/drop=%0d/%0d/%0d, required %0d/%0d/%0d",
                     name, p, a_in, a_pass, a_drop, in_e, pass_e, drop_e);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ifc.s_dec_ready !== 2'b11 || ifc.s_axis_tready !== 2'b00 || ifc.m_axis_tvalid !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_handshake: dec_ready=%b s_tready=%b m_tvalid=%b, required 11/00/00",
                     ifc.s_dec_ready, ifc.s_axis_tready, ifc.m_axis_tvalid);
        end
        check_cnt("reset", 0, 0, 0, 0);
        check_cnt("reset", 1, 0, 0, 0);
        checks++;
        if (ifs.m_axis_tvalid !== 1'b0 || ifs.cnt_in !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_small: m_tvalid=%b cnt_in=%0d, required 0/0", ifs.m_axis_tvalid, ifs.cnt_in);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_pass();
        int start;
        push_dec(0, 1'b1);
        ifc.s_axis_tuser_src[15:0] = 16'h5a3c;
        start = cyc;
        send_pkt(0, 3);
        checks++;
        if (cyc - start != 3) begin
            errors++;
            $display("[TB] FAIL pass_latency: took %0d cycles, required 3", cyc - start);
        end
        checks++;
        if (ifc.m_axis_tuser_src[15:0] !== 16'h5a3c) begin
            errors++;
            $display("[TB] FAIL tuser_passthrough: got %h, required 5a3c", ifc.m_axis_tuser_src[15:0]);
        end
        wait_drain(0);
        check_cnt("pass", 0, 1, 1, 0);
        checks++;
        if (ifc.s_axis_tready[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pass_fifo_empty: s_tready=%b, required 0", ifc.s_axis_tready[0]);
        end
    endtask

    task automatic test_drop();
        int start;
        clear_cnt(2'b01);
        push_dec(0, 1'b0);
        start = cyc;
        send_pkt(0, 4);
        checks++;
        if (cyc - start != 4) begin
            errors++;
            $display("[TB] FAIL drop_latency: took %0d cycles, required 4", cyc - start);
        end
        check_cnt("drop", 0, 1, 0, 1);
    endtask

    task automatic test_late_decision();
        beat_t bt;
        int    bad = 0;
        clear_cnt(2'b01);
        make_beat(1'b1, bt);
        ifc.s_axis_tdata[DW-1:0] = bt.data;
        ifc.s_axis_tkeep[KW-1:0] = bt.keep;
        ifc.s_axis_tlast[0]      = 1'b1;
        ifc.s_axis_tvalid[0]     = 1'b1;
        exp_q[0].push_back(bt);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ifc.s_axis_tready[0] !== 1'b0 || ifc.m_axis_tvalid[0] !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL late_stall: %0d stall cycles with ready/valid high, required 0", bad);
        end
        ifc.s_dec_valid[0] = 1'b1;
        ifc.s_dec_allow[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (ifc.s_axis_tready[0] !== 1'b0 || ifc.s_dec_ready[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL late_push_cycle: s_tready=%b dec_ready=%b, required 0/1",
                     ifc.s_axis_tready[0], ifc.s_dec_ready[0]);
        end
        tick();
        ifc.s_dec_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (ifc.s_axis_tready[0] !== 1'b1 || ifc.m_axis_tvalid[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL late_release: s_tready=%b m_tvalid=%b, required 1/1",
                     ifc.s_axis_tready[0], ifc.m_axis_tvalid[0]);
        end
        tick();
        ifc.s_axis_tvalid[0] = 1'b0;
        ifc.s_axis_tlast[0]  = 1'b0;
        checks++;
        if (ifc.s_axis_tready[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL late_popped: s_tready=%b, required 0", ifc.s_axis_tready[0]);
        end
        wait_drain(0);
        check_cnt("late", 0, 1, 1, 0);
    endtask

    task automatic test_fifo_full();
        bit pat[8] = '{1, 1, 0, 1, 1, 1, 1, 1};
        int n_push = 0;
        clear_cnt(2'b01);
        for (int i = 0; i < DEP; i++) push_dec(0, pat[i]);
        checks++;
        if (ifc.s_dec_ready[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_ready: dec_ready=%b, required 0", ifc.s_dec_ready[0]);
        end
        fork
            send_pkt(0, 1);
            push_dec(0, 1'b0);
        join
        checks++;
        if (ifc.s_dec_ready[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_refill: dec_ready=%b, required 0", ifc.s_dec_ready[0]);
        end
        send_pkt(0, 2);
        send_pkt(0, 2);
        send_pkt(0, 2);
        fork
            send_pkt(0, 1);
            push_dec(0, 1'b1);
        join
        while (ifc.s_dec_ready[0] && n_push < 10) begin
            push_dec(0, 1'b1);
            n_push++;
        end
        checks++;
        if (n_push != 3) begin
            errors++;
            $display("[TB] FAIL same_cycle_push_pop: %0d pushes to refill, required 3", n_push);
        end
        for (int i = 0; i < DEP; i++) send_pkt(0, 1);
        wait_drain(0);
        checks++;
        if (ifc.s_axis_tready[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_drained: s_tready=%b, required 0", ifc.s_axis_tready[0]);
        end
        check_cnt("fifo", 0, 13, 11, 2);
    endtask

    task automatic test_back_to_back_ready_toggle();
        int start;
        int p1_done = 0;
        clear_cnt(2'b11);
        push_dec(0, 1'b1);
        push_dec(1, 1'b0);
        start = cyc;
        fork
            send_pkt(0, 6);
            begin
                send_pkt(1, 5);
                p1_done = cyc;
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    ifc.m_axis_tready[0] = ~ifc.m_axis_tready[0];
                    tick();
                end
            end
        join
        ifc.m_axis_tready[0] = 1'b1;
        wait_drain(0);
        checks++;
        if (p1_done - start != 5) begin
            errors++;
            $display("[TB] FAIL parallel_drop_latency: took %0d cycles, required 5", p1_done - start);
        end
        check_cnt("toggle", 0, 1, 1, 0);
        check_cnt("toggle", 1, 1, 0, 1);
    endtask

    task automatic test_bypass();
        beat_t bt;
        clear_cnt(2'b01);
        ifc.cfg_bypass[0] = 1'b1;
        send_pkt(0, 2);
        send_pkt(0, 1);
        push_dec(0, 1'b0);
        send_pkt(0, 3);
        ifc.cfg_bypass[0] = 1'b0;
        fork
            send_pkt(0, 3);
            begin
                tick();
                ifc.cfg_bypass[0] = 1'b1;
            end
        join
        send_pkt(0, 1);
        wait_drain(0);
        check_cnt("bypass", 0, 5, 4, 1);
        make_beat(1'b1, bt);
        ifc.s_axis_tdata[DW-1:0] = bt.data;
        ifc.s_axis_tkeep[KW-1:0] = bt.keep;
        ifc.s_axis_tlast[0]      = 1'b1;
        ifc.s_axis_tvalid[0]     = 1'b1;
        ifc.cnt_clear[0]         = 1'b1;
        exp_q[0].push_back(bt);
        @(negedge clk);
        checks++;
        if (ifc.s_axis_tready[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_beat_ready: s_tready=%b, required 1", ifc.s_axis_tready[0]);
        end
        tick();
        ifc.s_axis_tvalid[0] = 1'b0;
        ifc.s_axis_tlast[0]  = 1'b0;
        ifc.cnt_clear[0]     = 1'b0;
        ifc.cfg_bypass[0]    = 1'b0;
        wait_drain(0);
        check_cnt("clear_vs_inc", 0, 0, 0, 0);
        check_cnt("clear_other_lane", 1, 1, 0, 1);
    endtask

    task automatic test_wrap();
        ifs.cfg_bypass    = 1'b1;
        ifs.m_axis_tready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            ifs.s_axis_tdata  = 8'(i);
            ifs.s_axis_tlast  = 1'b1;
            ifs.s_axis_tvalid = 1'b1;
            @(negedge clk);
            checks++;
            if (ifs.s_axis_tready !== 1'b1 || ifs.m_axis_tvalid !== 1'b1 || ifs.m_axis_tdata !== 8'(i)) begin
                errors++;
                $display("[TB] FAIL wrap_beat%0d: s_tready=%b m_tvalid=%b data=%h, required 1/1/%h",
                         i, ifs.s_axis_tready, ifs.m_axis_tvalid, ifs.m_axis_tdata, 8'(i));
            end
            tick();
            ifs.s_axis_tvalid = 1'b0;
            if (i == 7 || i == 8) begin
                checks++;
                if (ifs.cnt_in !== 3'(i)) begin
                    errors++;
                    $display("[TB] FAIL wrap_cnt_at_%0d: cnt_in=%0d, required %0d", i, ifs.cnt_in, 3'(i));
                end
            end
        end
        checks++;
        if (ifs.cnt_in !== 3'd1 || ifs.cnt_pass !== 3'd1 || ifs.cnt_drop !== 3'd0) begin
            errors++;
            $display("[TB] FAIL wrap_final: in/pass/drop=%0d/%0d/%0d, required 1/1/0",
                     ifs.cnt_in, ifs.cnt_pass, ifs.cnt_drop);
        end
    endtask

    task automatic test_reset_mid_packet();
        beat_t bt;
        push_dec(0, 1'b1);
        void'(dec_model[0].pop_front());
        for (int b = 0; b < 2; b++) begin
            make_beat(1'b0, bt);
            ifc.s_axis_tdata[DW-1:0] = bt.data;
            ifc.s_axis_tkeep[KW-1:0] = bt.keep;
            ifc.s_axis_tvalid[0]     = 1'b1;
            exp_q[0].push_back(bt);
            @(negedge clk);
            checks++;
            if (ifc.s_axis_tready[0] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL midrst_beat%0d: s_tready=%b, required 1", b, ifc.s_axis_tready[0]);
            end
            tick();
        end
        ifc.s_axis_tdata[63:0] = 64'hdead_beef_0bad_f00d;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ifc.m_axis_tvalid !== 2'b00 || ifc.s_axis_tready !== 2'b00 || ifc.s_dec_ready !== 2'b11) begin
            errors++;
            $display("[TB] FAIL midrst_outputs: m_tvalid=%b s_tready=%b dec_ready=%b, required 00/00/11",
                     ifc.m_axis_tvalid, ifc.s_axis_tready, ifc.s_dec_ready);
        end
        check_cnt("midrst", 0, 0, 0, 0);
        check_cnt("midrst", 1, 0, 0, 0);
        ifc.s_axis_tvalid[0] = 1'b0;
        for (int p = 0; p < NP; p++) begin
            exp_q[p].delete();
            dec_model[p].delete();
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (ifc.s_axis_tready[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_idle: s_tready=%b, required 0", ifc.s_axis_tready[0]);
        end
        push_dec(0, 1'b1);
        send_pkt(0, 2);
        wait_drain(0);
        check_cnt("after_rst", 0, 1, 1, 0);
    endtask

    initial begin
        ifc.cfg_bypass        = '0;
        ifc.cnt_clear         = '0;
        ifc.s_dec_valid       = '0;
        ifc.s_dec_allow       = '0;
        ifc.s_axis_tvalid     = '0;
        ifc.s_axis_tlast      = '0;
        ifc.s_axis_tdata      = '0;
        ifc.s_axis_tkeep      = '0;
        ifc.s_axis_tuser_size = '0;
        ifc.s_axis_tuser_src  = '0;
        ifc.s_axis_tuser_dst  = '0;
        ifc.m_axis_tready     = '1;
        ifs.cfg_bypass        = '0;
        ifs.cnt_clear         = '0;
        ifs.s_dec_valid       = '0;
        ifs.s_dec_allow       = '0;
        ifs.s_axis_tvalid     = '0;
        ifs.s_axis_tlast      = '0;
        ifs.s_axis_tdata      = '0;
        ifs.s_axis_tkeep      = '1;
        ifs.s_axis_tuser_size = '0;
        ifs.s_axis_tuser_src  = '0;
        ifs.s_axis_tuser_dst  = '0;
        ifs.m_axis_tready     = '1;

        test_reset();
        test_pass();
        test_drop();
        test_late_decision();
        test_fifo_full();
        test_back_to_back_ready_toggle();
        test_bypass();
        test_wrap();
        test_reset_mid_packet();
        wait_drain(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/packet_gate_mp.md
Name: packet_gate_mp

Overview:
Multi-port successor to the single-port 250 MHz packet gate in the box_250mhz plugin. It instantiates NUM_PORT independent lanes. Each lane holds a per-port decision FIFO filled by the rule engine, and forwards or drops whole AXIS packets according to the decision at the FIFO head. Each lane also keeps wrap-around in/pass/drop counters and supports a bypass mode. The block sits between the adapter RX streams and the QDMA-facing TX streams, all in the axis_aclk domain.

Parameters:
NUM_PORT, 2, number of independent lanes (1..4)
DATA_WIDTH, 512, AXIS tdata width per port
KEEP_WIDTH, 64, AXIS tkeep width per port (DATA_WIDTH/8)
DEC_DEPTH, 8, decision FIFO entries per port (power of 2, >=2)
CNT_WIDTH, 32, width of each statistics counter

Ports:
axis_aclk  in  1  single clock for all logic
box_rst  in  1  asynchronous, active-high reset
cfg_bypass  in  NUM_PORT  per-port bypass; 1 = forward all packets, ignore decisions
cnt_clear  in  NUM_PORT  per-port single-cycle counter clear
s_dec_valid  in  NUM_PORT  decision push strobe
s_dec_allow  in  NUM_PORT  1 = pass, 0 = drop
s_dec_ready  out  NUM_PORT  FIFO not full
s_axis_tvalid/tlast  in  NUM_PORT  ingress handshake and end-of-packet
s_axis_tdata  in  DATA_WIDTH*NUM_PORT  ingress data
s_axis_tkeep  in  KEEP_WIDTH*NUM_PORT  ingress keep
s_axis_tuser_size/src/dst  in  16*NUM_PORT each  ingress metadata
s_axis_tready  out  NUM_PORT  ingress ready
m_axis_tvalid/tlast  out  NUM_PORT  egress handshake and end-of-packet
m_axis_tdata/tkeep/tuser_size/src/dst  out  widths as ingress  egress payload (pass-through)
m_axis_tready  in  NUM_PORT  egress ready
cnt_in/cnt_pass/cnt_drop  out  CNT_WIDTH*NUM_PORT each  per-port packet counters

Behaviour:
- Lane p uses slice p of every vector. Lanes share no state.
- Reset (async assert, synchronous release): FSM=IDLE, FIFO empty, counters=0, s_dec_ready=1, s_axis_tready=0, m_axis_tvalid=0.
- Decision FIFO:
  - Push on s_dec_valid&&s_dec_ready. s_dec_ready=0 when DEC_DEPTH entries are held.
  - A pushed entry is visible at the head the next cycle.
  - Pop happens only on the first-beat handshake of a gated packet.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
- Lane FSM states: IDLE, PASS, DROP.
- IDLE:
  - A packet may start when s_tvalid=1 and (FIFO non-empty or cfg_bypass=1). The mode (bypass / head allow) is applied to the first beat combinationally, with zero added latency.
  - Pass mode: m_tvalid=s_tvalid, s_tready=m_tready, payload wired through.
  - Drop mode: s_tready=1, m_tvalid=0.
  - No decision and no bypass: s_tready=0, m_tvalid=0; the beat stalls.
  - On first-beat handshake: pop the FIFO unless bypass. If tlast=0, go to PASS or DROP; if tlast=1 (single-beat packet), stay IDLE.
- PASS and DROP apply the same per-beat rules as above. The tlast handshake returns the lane to IDLE.
- The mode is latched per packet. Toggling cfg_bypass mid-packet has no effect until the next packet.
- In bypass, decisions are neither popped nor discarded; the FIFO keeps filling until full.
- Counters increment on the tlast handshake:
  - cnt_in always increments.
  - cnt_pass increments for pass or bypass packets.
  - cnt_drop increments for drop packets.
  - Counters wrap modulo 2^CNT_WIDTH.
  - cnt_clear has priority: a clear coincident with an increment yields 0.
- Outputs are valid while the downstream AXIS protocol is respected: once m_tvalid=1 in PASS, it holds until the handshake because s_tvalid is held upstream.
- Reset mid-packet: the lane returns to IDLE immediately. The remaining beats of the interrupted packet are treated as a new packet by upstream convention.

Test Plan:
- Single port, push allow=1 then a 3-beat packet with m_tready=1 -> 3 beats out unchanged on consecutive cycles, cnt_in=1, cnt_pass=1, FIFO empty.
- Push allow=0 then a 4-beat packet -> s_tready=1 for 4 cycles, m_tvalid never 1, cnt_drop=1, cnt_pass=0.
- Packet arrives with FIFO empty, decision (allow=1) pushed 5 cycles later -> s_tready=0 until the cycle after the push, then the first beat passes. Single-beat packet (tlast on beat 0) -> lane stays IDLE, pop occurs.
- Push 8 decisions (DEC_DEPTH=8) -> s_dec_ready=0 after the 8th. Push and pop in the same cycle at full -> occupancy stays 8. Back-to-back pattern allow,drop,allow -> output contains packets 1 and 3 only.
- m_tready toggling 1/0 every cycle during a pass packet -> no beat lost or duplicated; the drop packet on port 1 in parallel is unaffected.
- cfg_bypass=1 with FIFO empty -> packets pass and cnt_pass increments. cnt_clear coincident with tlast -> counter reads 0. Counter preset near 2^32-1 -> wraps to 0. Assert box_rst mid-packet -> all outputs return to reset values within the same cycle.
